// File: rtl/multicycle_control_sequencer.sv
// Multicycle control sequencer: walks each instruction through fetch, decode and
// execute/shift/memory/branch phases, driving unpacked datapath controls.
module multicycle_control_sequencer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_AW      = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ir_in,
    input  logic [3:0]        status,
    input  logic              mem_ack,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              pc_sel,
    output logic [REG_AW-1:0] da,
    output logic [REG_AW-1:0] aa,
    output logic [REG_AW-1:0] ba,
    output logic              rw,
    output logic [4:0]        fs,
    output logic              mb,
    output logic              md,
    output logic [DATA_W-1:0] imm,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic [1:0]        fault
);

    localparam int unsigned TMO_W = 8;

    localparam logic [4:0] FS_ADD  = 5'b01000;
    localparam logic [4:0] FS_SUB  = 5'b01001;
    localparam logic [4:0] FS_NEG  = 5'b01011;
    localparam logic [4:0] FS_AND  = 5'b00000;
    localparam logic [4:0] FS_OR   = 5'b00100;
    localparam logic [4:0] FS_XOR  = 5'b01100;
    localparam logic [4:0] FS_NOT  = 5'b00110;
    localparam logic [4:0] FS_MOVA = 5'b00100;
    localparam logic [4:0] FS_SHL  = 5'b10000;
    localparam logic [4:0] FS_SHR  = 5'b10100;
    localparam logic [4:0] FS_MOVB = 5'b11000;

    // Register-form opcodes, keyed on the full IR[15:9]
    localparam logic [6:0] OP_MOVA = 7'h30;
    localparam logic [6:0] OP_MOVB = 7'h31;
    localparam logic [6:0] OP_CLR  = 7'h32;
    localparam logic [6:0] OP_SET  = 7'h33;
    localparam logic [6:0] OP_ADD  = 7'h34;
    localparam logic [6:0] OP_SUB  = 7'h35;
    localparam logic [6:0] OP_INC  = 7'h36;
    localparam logic [6:0] OP_DEC  = 7'h37;
    localparam logic [6:0] OP_NEG  = 7'h38;
    localparam logic [6:0] OP_AND  = 7'h39;
    localparam logic [6:0] OP_OR   = 7'h3A;
    localparam logic [6:0] OP_XOR  = 7'h3B;
    localparam logic [6:0] OP_NOT  = 7'h3C;
    localparam logic [6:0] OP_SHL  = 7'h3D;
    localparam logic [6:0] OP_SHR  = 7'h3E;
    localparam logic [6:0] OP_LDR  = 7'h20;
    localparam logic [6:0] OP_STR  = 7'h21;
    localparam logic [6:0] OP_BRZ  = 7'h22;
    localparam logic [6:0] OP_BRN  = 7'h23;
    localparam logic [6:0] OP_JMP  = 7'h24;

    // Immediate forms: IR[15:13]=10x group, IR[13:11] sub-op, IR[10:8] register
    localparam logic [2:0] IOP_ADI  = 3'd0;
    localparam logic [2:0] IOP_SBI  = 3'd1;
    localparam logic [2:0] IOP_ANDI = 3'd2;
    localparam logic [2:0] IOP_ORI  = 3'd3;
    localparam logic [2:0] IOP_XRI  = 3'd4;
    localparam logic [2:0] IOP_LDI  = 3'd5;
    localparam logic [2:0] IOP_STI  = 3'd6;

    localparam logic [1:0] BR_Z   = 2'd0;
    localparam logic [1:0] BR_N   = 2'd1;
    localparam logic [1:0] BR_JMP = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_SHIFT  = 3'd3,
        S_MEM    = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef struct packed {
        logic [REG_AW-1:0] da;
        logic [REG_AW-1:0] aa;
        logic [REG_AW-1:0] ba;
        logic [4:0]        fs;
        logic              mb;
        logic [DATA_W-1:0] imm;
        logic              store;
        logic [1:0]        br;
    } ctl_t;

    state_t            state_q;
    state_t            state_d;
    state_t            dec_state;
    ctl_t              ctl_q;
    ctl_t              dec;
    logic [15:0]       ir_q;
    logic [1:0]        stat_q;
    logic [2:0]        sh_cnt;
    logic [2:0]        dec_k;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [1:0]        fault_q;
    logic              tmo_hit;
    logic              waiting;
    logic              br_taken;

    logic [6:0]        op;
    logic [REG_AW-1:0] f_da;
    logic [REG_AW-1:0] f_aa;
    logic [REG_AW-1:0] f_ba;
    logic [REG_AW-1:0] f_ri;
    logic [DATA_W-1:0] imm_z;
    logic [DATA_W-1:0] imm_s;
    logic              vc_unused;

    // Branches only consult Z and N; V and C are not retained
    assign vc_unused = ^status[3:2];

    assign op    = ir_q[15:9];
    assign f_da  = REG_AW'(ir_q[8:6]);
    assign f_aa  = REG_AW'(ir_q[5:3]);
    assign f_ba  = REG_AW'(ir_q[2:0]);
    assign f_ri  = REG_AW'(ir_q[10:8]);
    assign imm_z = DATA_W'(ir_q[7:0]);
    assign imm_s = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign dec_k = ir_q[2:0];

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
    assign tmo_hit = waiting && !mem_ack && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
    assign br_taken = (ctl_q.br == BR_Z) ? stat_q[0] : stat_q[1];
    assign fault = fault_q;

    // Instruction decode from the captured IR into per-phase control fields
    always_comb begin
        dec       = '0;
        dec_state = S_TRAP;
        if (op[6:5] == 2'b10) begin
            dec_state = S_EXEC;
            dec.da    = f_ri;
            dec.aa    = f_ri;
            dec.mb    = 1'b1;
            dec.imm   = imm_z;
            case (op[4:2])
                IOP_ADI:  begin dec.fs = FS_ADD; dec.imm = imm_s; end
                IOP_SBI:  begin dec.fs = FS_SUB; dec.imm = imm_s; end
                IOP_ANDI: dec.fs = FS_AND;
                IOP_ORI:  dec.fs = FS_OR;
                IOP_XRI:  dec.fs = FS_XOR;
                IOP_LDI: begin
                    dec.fs    = FS_MOVB;
                    dec.aa    = '0;
                    dec_state = S_MEM;
                end
                IOP_STI: begin
                    dec.fs    = FS_MOVB;
                    dec.da    = '0;
                    dec.aa    = '0;
                    dec.ba    = f_ri;
                    dec.store = 1'b1;
                    dec_state = S_MEM;
                end
                default: dec.fs = FS_MOVB;
            endcase
        end else begin
            dec_state = S_EXEC;
            dec.da    = f_da;
            dec.aa    = f_aa;
            dec.ba    = f_ba;
            case (op)
                OP_MOVA: begin dec.fs = FS_MOVA; dec.ba = f_aa; end
                OP_MOVB: dec.fs = FS_MOVB;
                OP_CLR:  begin dec.fs = FS_AND; dec.mb = 1'b1; end
                OP_SET:  begin dec.fs = FS_OR; dec.mb = 1'b1; dec.imm = '1; end
                OP_ADD:  dec.fs = FS_ADD;
                OP_SUB:  dec.fs = FS_SUB;
                OP_INC:  begin dec.fs = FS_ADD; dec.mb = 1'b1; dec.imm = DATA_W'(1); end
                OP_DEC:  begin dec.fs = FS_SUB; dec.mb = 1'b1; dec.imm = DATA_W'(1); end
                OP_NEG:  dec.fs = FS_NEG;
                OP_AND:  dec.fs = FS_AND;
                OP_OR:   dec.fs = FS_OR;
                OP_XOR:  dec.fs = FS_XOR;
                OP_NOT:  dec.fs = FS_NOT;
                OP_SHL, OP_SHR: begin
                    if (dec_k == 3'd0) begin
                        dec.fs = FS_MOVA;
                        dec.ba = f_aa;
                    end else begin
                        dec.fs    = (op == OP_SHL) ? FS_SHL : FS_SHR;
                        dec.ba    = '0;
                        dec_state = S_SHIFT;
                    end
                end
                OP_LDR: begin
                    dec.ba    = '0;
                    dec_state = S_MEM;
                end
                OP_STR: begin
                    dec.da    = '0;
                    dec.store = 1'b1;
                    dec_state = S_MEM;
                end
                OP_BRZ, OP_BRN: begin
                    dec.da    = '0;
                    dec.aa    = '0;
                    dec.ba    = '0;
                    dec.imm   = imm_s;
                    dec.br    = (op == OP_BRN) ? BR_N : BR_Z;
                    dec_state = S_BRANCH;
                end
                OP_JMP: begin
                    dec.da    = '0;
                    dec.ba    = '0;
                    dec.br    = BR_JMP;
                    dec_state = S_BRANCH;
                end
                default: dec_state = S_TRAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // IR, decoded fields, branch flags, shift and timeout counters, fault code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= '0;
            ctl_q   <= '0;
            stat_q  <= '0;
            sh_cnt  <= '0;
            tmo_cnt <= '0;
            fault_q <= 2'b00;
        end else begin
            if (state_q == S_FETCH && mem_ack) begin
                ir_q <= ir_in;
            end
            if (state_q == S_DECODE) begin
                ctl_q  <= dec;
                stat_q <= status[1:0];
                sh_cnt <= dec_k;
                if (dec_state == S_TRAP) begin
                    fault_q <= 2'b01;
                end
            end
            // In-place shift: after the first step the source is the destination
            if (state_q == S_SHIFT) begin
                ctl_q.aa <= ctl_q.da;
                sh_cnt   <= sh_cnt - 3'd1;
            end
            if (waiting && !mem_ack) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                fault_q <= 2'b10;
            end
        end
    end

    // Next state and datapath controls; everything is held low while in reset
    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        pc_sel  = 1'b0;
        da      = '0;
        aa      = '0;
        ba      = '0;
        rw      = 1'b0;
        fs      = '0;
        mb      = 1'b0;
        md      = 1'b0;
        imm     = '0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_load = 1'b1;
                        state_d = S_DECODE;
                    end else if (tmo_hit) begin
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    busy    = 1'b1;
                    state_d = dec_state;
                end
                S_EXEC: begin
                    busy    = 1'b1;
                    rw      = 1'b1;
                    pc_inc  = 1'b1;
                    da      = ctl_q.da;
                    aa      = ctl_q.aa;
                    ba      = ctl_q.ba;
                    fs      = ctl_q.fs;
                    mb      = ctl_q.mb;
                    imm     = ctl_q.imm;
                    state_d = S_FETCH;
                end
                S_SHIFT: begin
                    busy = 1'b1;
                    rw   = 1'b1;
                    da   = ctl_q.da;
                    aa   = ctl_q.aa;
                    fs   = ctl_q.fs;
                    if (sh_cnt == 3'd1) begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    busy    = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = ctl_q.store;
                    da      = ctl_q.da;
                    aa      = ctl_q.aa;
                    ba      = ctl_q.ba;
                    fs      = ctl_q.fs;
                    mb      = ctl_q.mb;
                    imm     = ctl_q.imm;
                    if (mem_ack) begin
                        pc_inc  = 1'b1;
                        rw      = !ctl_q.store;
                        md      = !ctl_q.store;
                        state_d = S_FETCH;
                    end else if (tmo_hit) begin
                        state_d = S_TRAP;
                    end
                end
                S_BRANCH: begin
                    busy    = 1'b1;
                    imm     = ctl_q.imm;
                    state_d = S_FETCH;
                    if (ctl_q.br == BR_JMP) begin
                        pc_load = 1'b1;
                        pc_sel  = 1'b1;
                        aa      = ctl_q.aa;
                    end else if (br_taken) begin
                        pc_load = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
                S_TRAP: begin
                    busy = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected controls, a negedge
// monitor pops and compares them against the sequencer outputs.
module tb_multicycle_control_sequencer;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned REG_AW      = 3;
    localparam int unsigned MEM_TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic [15:0]       ir_in;
    logic [3:0]        status;
    logic              mem_ack;
    logic              ir_load;
    logic              pc_inc;
    logic              pc_load;
    logic              pc_sel;
    logic [REG_AW-1:0] da;
    logic [REG_AW-1:0] aa;
    logic [REG_AW-1:0] ba;
    logic              rw;
    logic [4:0]        fs;
    logic              mb;
    logic              md;
    logic [DATA_W-1:0] imm;
    logic              mem_req;
    logic              mem_we;
    logic              busy;
    logic [1:0]        fault;

    multicycle_control_sequencer #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .status(status), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .pc_sel(pc_sel),
        .da(da), .aa(aa), .ba(ba), .rw(rw), .fs(fs), .mb(mb), .md(md), .imm(imm),
        .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .fault(fault)
    );

    typedef struct packed {
        logic        ir_load;
        logic        pc_inc;
        logic        pc_load;
        logic        pc_sel;
        logic [2:0]  da;
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic        rw;
        logic [4:0]  fs;
        logic        mb;
        logic        md;
        logic [15:0] imm;
        logic        mem_req;
        logic        mem_we;
        logic        busy;
        logic [1:0]  fault;
    } vec_t;

    vec_t  act;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    q_cyc[$];
    vec_t  q_exp[$];
    vec_t  q_msk[$];
    string q_nm[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        act.ir_load = ir_load;
        act.pc_inc  = pc_inc;
        act.pc_load = pc_load;
        act.pc_sel  = pc_sel;
        act.da      = da;
        act.aa      = aa;
        act.ba      = ba;
        act.rw      = rw;
        act.fs      = fs;
        act.mb      = mb;
        act.md      = md;
        act.imm     = imm;
        act.mem_req = mem_req;
        act.mem_we  = mem_we;
        act.busy    = busy;
        act.fault   = fault;
    end

    // Monitor: compares every expectation stamped for the current cycle
    always @(negedge clk) begin : monitor
        int    c;
        vec_t  e;
        vec_t  m;
        string nm;
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            c  = q_cyc.pop_front();
            e  = q_exp.pop_front();
            m  = q_msk.pop_front();
            nm = q_nm.pop_front();
            checks++;
            if (c != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)", nm, c, cyc);
            end else if (((act ^ e) & m) != '0) begin
                failures++;
                $display("FAIL %s (cycle %0d): got %h required %h mask %h", nm, cyc, act, e, m);
            end
        end
    end

    function automatic vec_t v_fetch(input logic ack);
        vec_t v = '0;
        v.mem_req = 1'b1;
        v.ir_load = ack;
        return v;
    endfunction

    function automatic vec_t v_busy();
        vec_t v = '0;
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t m_all();
        vec_t v = '1;
        return v;
    endfunction

    task automatic step(input logic rn, input logic [15:0] ir, input logic ack,
                        input logic [3:0] st, input vec_t e, input vec_t m, input string nm);
        @(posedge clk);
        #1;
        rst_n   = rn;
        ir_in   = ir;
        mem_ack = ack;
        status  = st;
        q_cyc.push_back(cyc);
        q_exp.push_back(e);
        q_msk.push_back(m);
        q_nm.push_back(nm);
    endtask

    task automatic fetch_decode(input logic [15:0] ir, input logic [3:0] st,
                                input logic dec_ack, input string nm);
        step(1'b1, ir, 1'b1, 4'h0, v_fetch(1'b1), m_all(), {nm, " fetch"});
        step(1'b1, 16'h0000, dec_ack, st, v_busy(), m_all(), {nm, " decode"});
    endtask

    task automatic do_reset();
        step(1'b0, 16'h0000, 1'b1, 4'hF, '0, m_all(), "reset hold");
        step(1'b0, 16'h0000, 1'b0, 4'h0, '0, m_all(), "reset hold 2");
    endtask

    initial begin : stim
        vec_t e;
        vec_t m;
        rst_n   = 1'b1;
        ir_in   = '0;
        status  = '0;
        mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        do_reset();

        // ADD R3,R1,R2
        fetch_decode(16'h68CA, 4'h0, 1'b0, "add");
        e = v_busy(); e.rw = 1; e.pc_inc = 1; e.da = 3; e.aa = 1; e.ba = 2; e.fs = 5'b01000;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), "add exec");

        // SHL R4,R4 by 3
        fetch_decode(16'h7B23, 4'h0, 1'b0, "shl3");
        for (int k = 1; k <= 3; k++) begin
            e = v_busy(); e.rw = 1; e.da = 4; e.aa = 4; e.fs = 5'b10000; e.pc_inc = (k == 3);
            step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), $sformatf("shl3 step%0d", k));
        end

        // SHR R5,R6 by 0 acts as MOVA
        fetch_decode(16'h7D70, 4'h0, 1'b0, "shr0");
        e = v_busy(); e.rw = 1; e.pc_inc = 1; e.da = 5; e.aa = 6; e.ba = 6; e.fs = 5'b00100;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), "shr0 mova");

        // ADI R2,0x80 sign-extends; ANDI R2,0x80 zero-extends; INC R1
        fetch_decode(16'h8280, 4'h0, 1'b0, "adi");
        e = v_busy(); e.rw = 1; e.pc_inc = 1; e.da = 2; e.aa = 2; e.fs = 5'b01000; e.mb = 1; e.imm = 16'hFF80;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), "adi exec");
        fetch_decode(16'h9280, 4'h0, 1'b0, "andi");
        e = v_busy(); e.rw = 1; e.pc_inc = 1; e.da = 2; e.aa = 2; e.fs = 5'b00000; e.mb = 1; e.imm = 16'h0080;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), "andi exec");
        fetch_decode(16'h6C48, 4'h0, 1'b0, "inc");
        e = v_busy(); e.rw = 1; e.pc_inc = 1; e.da = 1; e.aa = 1; e.fs = 5'b01000; e.mb = 1; e.imm = 16'h0001;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), "inc exec");

        // BRZ 0xFE taken (Z sampled at decode, cleared afterwards)
        m = m_all(); m.da = '0; m.aa = '0; m.ba = '0;
        fetch_decode(16'h44FE, 4'b0001, 1'b0, "brz taken");
        e = v_busy(); e.pc_load = 1; e.imm = 16'hFFFE;
        step(1'b1, 16'h0, 1'b0, 4'b0000, e, m, "brz taken branch");
        // BRZ not taken (Z set only after decode)
        fetch_decode(16'h44FE, 4'b0000, 1'b0, "brz not");
        e = v_busy(); e.pc_inc = 1;
        m.imm = '0;
        step(1'b1, 16'h0, 1'b0, 4'b0001, e, m, "brz not-taken branch");
        // BRN +5 taken on N
        m = m_all(); m.da = '0; m.aa = '0; m.ba = '0;
        fetch_decode(16'h4605, 4'b0010, 1'b0, "brn");
        e = v_busy(); e.pc_load = 1; e.imm = 16'h0005;
        step(1'b1, 16'h0, 1'b0, 4'b0000, e, m, "brn taken branch");
        // JMP R5
        m = m_all(); m.da = '0; m.ba = '0; m.imm = '0;
        fetch_decode(16'h4828, 4'h0, 1'b0, "jmp");
        e = v_busy(); e.pc_load = 1; e.pc_sel = 1; e.aa = 5;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m, "jmp branch");

        // STR [R3],R7 with immediate ack
        m = m_all(); m.da = '0; m.fs = '0; m.mb = '0; m.imm = '0;
        fetch_decode(16'h421F, 4'h0, 1'b0, "str");
        e = v_busy(); e.mem_req = 1; e.mem_we = 1; e.aa = 3; e.ba = 7; e.pc_inc = 1;
        step(1'b1, 16'h0, 1'b1, 4'h0, e, m, "str ack");

        // LDR R6,[R2], ack at decode ignored, memory ack after 4 waits
        m = m_all(); m.ba = '0; m.fs = '0; m.mb = '0; m.imm = '0;
        fetch_decode(16'h4190, 4'h0, 1'b1, "ldr");
        for (int i = 1; i <= 5; i++) begin
            e = v_busy(); e.mem_req = 1; e.da = 6; e.aa = 2;
            if (i == 5) begin
                e.rw = 1; e.md = 1; e.pc_inc = 1;
            end
            step(1'b1, 16'h0, (i == 5), 4'h0, e, m, $sformatf("ldr mem cycle%0d", i));
        end

        // Reset during the second step of SHL R2,R1 by 5
        fetch_decode(16'h7A8D, 4'h0, 1'b0, "shl5");
        e = v_busy(); e.rw = 1; e.da = 2; e.aa = 1; e.fs = 5'b10000;
        step(1'b1, 16'h0, 1'b0, 4'h0, e, m_all(), "shl5 step1");
        step(1'b0, 16'h0, 1'b0, 4'h0, '0, m_all(), "shl5 reset mid-shift");
        step(1'b0, 16'h0, 1'b0, 4'h0, '0, m_all(), "shl5 reset held");
        step(1'b1, 16'h0, 1'b0, 4'h0, v_fetch(1'b0), m_all(), "post-reset fetch wait");
        step(1'b1, 16'h0, 1'b0, 4'h0, v_fetch(1'b0), m_all(), "post-reset fetch wait 2");

        // LDR with ack withheld: 15 waiting cycles then memory-timeout trap
        m = m_all(); m.ba = '0; m.fs = '0; m.mb = '0; m.imm = '0;
        fetch_decode(16'h4190, 4'h0, 1'b0, "ldr tmo");
        for (int i = 1; i <= 15; i++) begin
            e = v_busy(); e.mem_req = 1; e.da = 6; e.aa = 2;
            step(1'b1, 16'h0, 1'b0, 4'h0, e, m, $sformatf("ldr tmo wait%0d", i));
        end
        e = v_busy(); e.fault = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0, 1'b1, 4'h0, e, m_all(), $sformatf("mem timeout trap%0d", i));
        end
        do_reset();

        // Undefined opcode 0x7F traps and ignores mem_ack pulses
        fetch_decode(16'hFE00, 4'h0, 1'b0, "illegal");
        e = v_busy(); e.fault = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h68CA, logic'(i % 2), 4'hF, e, m_all(), $sformatf("illegal trap%0d", i));
        end
        do_reset();
        step(1'b1, 16'h0, 1'b0, 4'h0, v_fetch(1'b0), m_all(), "final fetch idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q_cyc.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", q_cyc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
